// File: rtl/cmd_rx_core_if.sv
`default_nettype none
// ============================================================================
// Module      : cmd_rx_core_if
// Description : basil-style 8-bit register/memory bus seen by cmd_rx_core.
//               The master drives address, write data and strobes; the slave
//               returns registered read data.
// Revision    : 1.0 - initial release
// ============================================================================
interface cmd_rx_core_if #(
  parameter int ABUSWIDTH = 16
);
  logic [ABUSWIDTH-1:0] BUS_ADD;
  logic [7:0]           BUS_DATA_IN;
  logic                 BUS_RD;
  logic                 BUS_WR;
  logic [7:0]           BUS_DATA_OUT;

  modport master (
    output BUS_ADD,
    output BUS_DATA_IN,
    output BUS_RD,
    output BUS_WR,
    input  BUS_DATA_OUT
  );

  modport slave (
    input  BUS_ADD,
    input  BUS_DATA_IN,
    input  BUS_RD,
    input  BUS_WR,
    output BUS_DATA_OUT
  );
endinterface
`default_nettype wire

// File: rtl/cmd_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : cmd_rx_core
// Description : Bus-mapped serial command receiver. Samples CMD_DATA_IN once
//               per clock after an armed start strobe, decodes NRZ or
//               Manchester (IEEE / Thomas) MSB-first into bytes and stores
//               them in a byte memory readable at bus address 16 and up.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_rx_core #(
  parameter int         ABUSWIDTH   = 16,
  parameter int         RX_MEM_SIZE = 2048,
  parameter logic [7:0] VERSION     = 8'd1
) (
  input  wire logic     BUS_CLK,
  input  wire logic     BUS_RST,
  cmd_rx_core_if.slave  bus,
  input  wire logic     CMD_DATA_IN,
  input  wire logic     CMD_START_IN,
  output logic          RX_BUSY,
  output logic          RX_DONE
);

  localparam int c_mem_bytes = RX_MEM_SIZE - 16;
  localparam int c_mem_aw    = (c_mem_bytes > 1) ? $clog2(c_mem_bytes) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RECV  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_mode;        // [1:0] decode mode, [7:2] scratch
  logic [15:0] r_conf_size;   // bus-visible frame length
  logic [15:0] r_size_lat;    // frame length captured at arm
  logic [15:0] r_bit_cnt;
  logic [7:0]  r_err_cnt;
  logic        r_done;
  logic        r_ovf;
  logic        r_code_err;
  logic [7:0]  r_shift;
  logic        r_first;       // first-half sample of the current Manchester bit
  logic        r_half;        // 1 while waiting for the second half
  logic        r_rx_done;
  logic [7:0]  r_data_out;

  logic [7:0]  r_mem [c_mem_bytes];

  // ---------------------------------------------------------------------------
  // Bus address decode
  // ---------------------------------------------------------------------------
  logic        w_is_reg;
  logic [3:0]  w_reg_sel;
  logic        w_in_mem;
  logic        w_soft_rst;
  logic        w_arm;

  assign w_is_reg   = (bus.BUS_ADD[ABUSWIDTH-1:4] == '0);
  assign w_reg_sel  = bus.BUS_ADD[3:0];
  assign w_in_mem   = !w_is_reg && (32'(bus.BUS_ADD) < 32'(RX_MEM_SIZE));
  assign w_soft_rst = bus.BUS_WR && w_is_reg && (w_reg_sel == 4'd0);
  assign w_arm      = bus.BUS_WR && w_is_reg && (w_reg_sel == 4'd1) && (r_state == ST_IDLE);

  // ---------------------------------------------------------------------------
  // Line decoding. A frame's first sample is taken in ARMED together with the
  // start strobe, so the half-phase is forced to "first half" there.
  // ---------------------------------------------------------------------------
  logic        w_sample;
  logic        w_manch;
  logic        w_half_eff;
  logic        w_bit_valid;
  logic        w_bit;
  logic        w_code_err;
  logic [15:0] w_bit_cnt_nxt;
  logic        w_last;
  logic        w_byte_end;
  logic [7:0]  w_byte;
  logic        w_idx_ok;
  logic        w_mem_we;
  logic        w_fin;

  assign w_sample   = ((r_state == ST_ARMED) && CMD_START_IN) || (r_state == ST_RECV);
  assign w_manch    = r_mode[1];
  assign w_half_eff = (r_state == ST_RECV) ? r_half : 1'b0;
  assign w_bit_valid = w_sample && (!w_manch || w_half_eff);
  // Thomas takes the first half, IEEE the second; on a code error both halves
  // are equal, so either choice already yields the second-half value.
  assign w_bit      = (w_manch && r_mode[0]) ? r_first : CMD_DATA_IN;
  assign w_code_err = w_sample && w_manch && w_half_eff && (r_first == CMD_DATA_IN);

  assign w_bit_cnt_nxt = r_bit_cnt + 16'd1;
  assign w_last        = w_bit_valid && (w_bit_cnt_nxt == r_size_lat);
  assign w_byte_end    = w_bit_valid && ((r_bit_cnt[2:0] == 3'd7) || w_last);
  // Left-align a trailing partial byte; stale high bits shift out.
  assign w_byte        = {r_shift[6:0], w_bit} << (3'd7 - r_bit_cnt[2:0]);
  assign w_idx_ok      = (32'(r_bit_cnt[15:3]) < 32'(c_mem_bytes));
  assign w_mem_we      = w_byte_end && w_idx_ok && !w_soft_rst;

  // State register
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and completion strobe
  always_comb begin
    w_state_nxt = r_state;
    w_fin       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arm) begin
          if (r_conf_size == 16'd0) begin
            w_fin = 1'b1;
          end else begin
            w_state_nxt = ST_ARMED;
          end
        end
      end
      ST_ARMED: begin
        if (CMD_START_IN) begin
          w_state_nxt = w_last ? ST_IDLE : ST_RECV;
          w_fin       = w_last;
        end
      end
      ST_RECV: begin
        if (w_last) begin
          w_state_nxt = ST_IDLE;
          w_fin       = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_soft_rst) begin
      w_state_nxt = ST_IDLE;
      w_fin       = 1'b0;
    end
  end

  // Read data mux for the register window
  logic [7:0] w_reg_rd;
  always_comb begin
    w_reg_rd = 8'd0;
    case (w_reg_sel)
      4'd0:    w_reg_rd = VERSION;
      4'd1:    w_reg_rd = {5'b0, r_code_err, r_ovf, r_done};
      4'd2:    w_reg_rd = r_mode;
      4'd3:    w_reg_rd = r_conf_size[7:0];
      4'd4:    w_reg_rd = r_conf_size[15:8];
      4'd5:    w_reg_rd = r_bit_cnt[7:0];
      4'd6:    w_reg_rd = r_bit_cnt[15:8];
      4'd7:    w_reg_rd = r_err_cnt;
      default: w_reg_rd = 8'd0;
    endcase
  end

  // Control registers, decoder state, status and bus read data
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      r_mode      <= 8'd0;
      r_conf_size <= 16'd0;
      r_size_lat  <= 16'd0;
      r_bit_cnt   <= 16'd0;
      r_err_cnt   <= 8'd0;
      r_done      <= 1'b1;
      r_ovf       <= 1'b0;
      r_code_err  <= 1'b0;
      r_shift     <= 8'd0;
      r_first     <= 1'b0;
      r_half      <= 1'b0;
      r_rx_done   <= 1'b0;
      r_data_out  <= 8'd0;
    end else if (w_soft_rst) begin
      r_mode      <= 8'd0;
      r_conf_size <= 16'd0;
      r_size_lat  <= 16'd0;
      r_bit_cnt   <= 16'd0;
      r_err_cnt   <= 8'd0;
      r_done      <= 1'b1;
      r_ovf       <= 1'b0;
      r_code_err  <= 1'b0;
      r_shift     <= 8'd0;
      r_first     <= 1'b0;
      r_half      <= 1'b0;
      r_rx_done   <= 1'b0;
      r_data_out  <= 8'd0;
    end else begin
      r_rx_done <= w_fin;

      if (bus.BUS_WR && w_is_reg) begin
        case (w_reg_sel)
          4'd2:    r_mode             <= bus.BUS_DATA_IN;
          4'd3:    r_conf_size[7:0]   <= bus.BUS_DATA_IN;
          4'd4:    r_conf_size[15:8]  <= bus.BUS_DATA_IN;
          default: ;
        endcase
      end

      if (bus.BUS_RD) begin
        if (w_is_reg) begin
          r_data_out <= w_reg_rd;
        end else if (w_in_mem) begin
          r_data_out <= r_mem[c_mem_aw'(bus.BUS_ADD - ABUSWIDTH'(16))];
        end else begin
          r_data_out <= 8'd0;
        end
      end

      if (w_arm) begin
        r_size_lat <= r_conf_size;
        r_bit_cnt  <= 16'd0;
        r_err_cnt  <= 8'd0;
        r_ovf      <= 1'b0;
        r_code_err <= 1'b0;
        r_half     <= 1'b0;
        r_done     <= (r_conf_size == 16'd0);
      end

      if (w_sample && w_manch) begin
        if (!w_half_eff) begin
          r_first <= CMD_DATA_IN;
          r_half  <= 1'b1;
        end else begin
          r_half  <= 1'b0;
        end
      end

      if (w_code_err) begin
        r_code_err <= 1'b1;
        if (r_err_cnt != 8'hFF) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end

      if (w_bit_valid) begin
        r_shift   <= {r_shift[6:0], w_bit};
        r_bit_cnt <= w_bit_cnt_nxt;
      end

      if (w_byte_end && !w_idx_ok) begin
        r_ovf <= 1'b1;
      end

      if (w_last) begin
        r_done <= 1'b1;
      end
    end
  end

  // Receive-side memory write port; contents survive reset
  always_ff @(posedge BUS_CLK) begin
    if (w_mem_we) begin
      r_mem[c_mem_aw'(r_bit_cnt[15:3])] <= w_byte;
    end
  end

  assign bus.BUS_DATA_OUT = r_data_out;
  assign RX_BUSY          = (r_state != ST_IDLE);
  assign RX_DONE          = r_rx_done;

endmodule
`default_nettype wire
